bcd_operand_regfile: RTL
========================

Name: bcd_operand_regfile

Overview:
Parametrised successor to the two-entry keypad operand register. Keypad digits are collected into an NDIG-digit BCD entry buffer, which supports backspace and clear and drives the display. On commit, a multi-cycle BCD-to-binary conversion runs with overflow saturation, and the result is written into one of NREG DW-bit registers. Two registered read ports feed the ALU.

Parameters:
NDIG, 4, number of BCD digits in the entry buffer (1..8)
DW, 16, register/result width in bits
AW, 2, register address width; NREG = 2**AW
CW (localparam), clog2(NDIG+1), digit-count width

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  synchronous reset, active-high
key_valid  in  1  one-cycle digit strobe
key_digit  in  4  BCD digit; values 10..15 ignored
key_bksp  in  1  delete most recently entered digit
key_clr  in  1  clear entry buffer
commit  in  1  convert buffer and write to wr_addr
wr_addr  in  AW  destination register
rd_addr_a  in  AW  read port A address
rd_addr_b  in  AW  read port B address
dout_a  out  DW  RF[rd_addr_a], registered
dout_b  out  DW  RF[rd_addr_b], registered
dis_digits  out  4*NDIG  entry buffer; [3:0] = least-significant digit
dig_count  out  CW  digits currently entered
entry_full  out  1  dig_count == NDIG
busy  out  1  conversion/write in progress
done  out  1  one-cycle pulse after RF write
ovf  out  1  valid with done; 1 = result saturated

Behaviour:
- Reset: all RF entries 0; buffer 0; dig_count 0; state IDLE; busy, done, ovf, dout_a, dout_b all 0.
- RST during CONV or WRITE aborts. No RF write occurs and done does not pulse.
- FSM states: IDLE, CONV, WRITE. busy = (state != IDLE).
- Entry edits apply in IDLE only. Priority within one cycle: commit > key_clr > key_bksp > key_valid.
- key_valid with digit <= 9 and not full: buffer shifts left 4 bits, new digit enters [3:0], dig_count++.
  - Full: digit ignored.
  - Digits 10..15: ignored.
  - Leading zeros are accepted and counted.
- key_bksp: buffer shifts right 4 bits, MSD becomes 0, dig_count-- if > 0. At count 0 there is no change.
- key_clr: buffer = 0, dig_count = 0.
- commit in IDLE: state goes to CONV and latches wr_addr. Commit with dig_count 0 converts value 0.
- CONV runs exactly NDIG cycles, MSD first.
  - Each cycle: acc = acc*10 + digit, using a DW+4-bit accumulator.
  - If any bit above DW-1 is set after any step, a sticky ovf_int is set.
  - Latency is fixed regardless of dig_count.
- WRITE (1 cycle):
  - RF[latched wr_addr] is written with acc[DW-1:0], or all-ones if ovf_int.
  - Buffer and dig_count are cleared.
  - State returns to IDLE.
- done and ovf are registered. Both go high on the edge that performs the RF write, for one cycle. ovf is 0 whenever done is 0.
- busy timing: high for NDIG+1 cycles, starting the cycle after commit is sampled. Next commit is accepted in the done cycle.
- Inputs while busy: key_*, commit and wr_addr changes are ignored.
- Read ports: dout_x at edge k = RF[rd_addr_x] before edge k. Reads have 1-cycle latency with no write-through. A value written at edge E appears on dout at edge E+1 (one cycle after done rises).
- Both read ports may address the same register.

Test Plan:
- Default params, after reset: keys 1,2,3,4; commit with wr_addr=2 → busy high 5 cycles, done=1, ovf=0, dis_digits 0x0000, dig_count 0. Next cycle with rd_addr_a=2: dout_a = 0x04D2.
- Keys 9,8,7,6,5 → dis_digits 0x9876, dig_count 4, entry_full 1. Then key_bksp → 0x0987, dig_count 3, entry_full 0. key_digit 12 with key_valid → no change.
- key_clr and key_valid (digit 7) in the same cycle → buffer 0, count 0. key_bksp at count 0 → no change. Commit with empty buffer to wr_addr=1 → RF[1] = 0 after done.
- NDIG=3, DW=8 instance: keys 2,5,6 and commit → done with ovf=1, RF = 0xFF. Keys 2,5,5 and commit → ovf=0, RF = 0xFF. Keys 0,4,2 → RF = 0x2A.
- Keys 5,5, commit to wr_addr=3; during busy pulse key_valid, key_clr, and commit with wr_addr=0 → all ignored, RF[3]=55, RF[0] unchanged. Repeat with RST asserted in 2nd CONV cycle → no done, RF[3] stays 0 after reset, busy 0 next cycle.
- rd_addr_a = rd_addr_b = 3 while RF[3] is being overwritten from 55 to 77 → both ports show 55 in the done cycle and 77 the cycle after.

Source files
------------

// File: rtl/bcd_operand_regfile.sv
// bcd_operand_regfile: keypad BCD entry buffer, multi-cycle BCD-to-binary commit into a register file, two registered read ports
//   CLK, RST                   clock, synchronous active-high reset
//   key_valid/key_digit        digit strobe and BCD digit (10..15 ignored)
//   key_bksp, key_clr          delete last digit, clear buffer
//   commit, wr_addr            convert buffer and write RF[wr_addr]
//   rd_addr_a/b, dout_a/b      registered read ports (1-cycle latency, no write-through)
//   dis_digits, dig_count      entry buffer contents and digit count
//   entry_full, busy, done, ovf status; ovf qualifies done (result saturated)
module bcd_operand_regfile #(
  parameter int NDIG = 4,
  parameter int DW = 16,
  parameter int AW = 2,
  localparam int CW = $clog2(NDIG + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              key_valid,
  input  logic [3:0]        key_digit,
  input  logic              key_bksp,
  input  logic              key_clr,
  input  logic              commit,
  input  logic [AW-1:0]     wr_addr,
  input  logic [AW-1:0]     rd_addr_a,
  input  logic [AW-1:0]     rd_addr_b,
  output logic [DW-1:0]     dout_a,
  output logic [DW-1:0]     dout_b,
  output logic [4*NDIG-1:0] dis_digits,
  output logic [CW-1:0]     dig_count,
  output logic              entry_full,
  output logic              busy,
  output logic              done,
  output logic              ovf
);
  localparam int NREG = 2 ** AW;
  typedef enum logic [1:0] {IDLE, CONV, WRITE} state_t;
  state_t state_q, state_d;
  logic [4*NDIG-1:0] buf_q, buf_d, sh_q, sh_d;
  logic [CW-1:0] cnt_q, cnt_d, step_q, step_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW+3:0] acc_q, acc_d;
  logic ovfi_q, ovfi_d, we;
  logic [DW-1:0] rf_q [NREG];
  logic [DW-1:0] dout_a_q, dout_b_q;
  logic done_q, ovf_q;
  assign entry_full = cnt_q == CW'(NDIG);
  always_comb begin
    state_d = state_q;
    buf_d = buf_q;
    cnt_d = cnt_q;
    sh_d = sh_q;
    step_d = step_q;
    waddr_d = waddr_q;
    acc_d = acc_q;
    ovfi_d = ovfi_q;
    we = 1'b0;
    case (state_q)
      IDLE:
        if (commit) begin
          state_d = CONV;
          waddr_d = wr_addr;
          sh_d = buf_q;
          step_d = '0;
          acc_d = '0;
          ovfi_d = 1'b0;
        end else if (key_clr) begin
          buf_d = '0;
          cnt_d = '0;
        end else if (key_bksp) begin
          buf_d = cnt_q != '0 ? buf_q >> 4 : buf_q;
          cnt_d = cnt_q != '0 ? cnt_q - 1'b1 : cnt_q;
        end else if (key_valid && key_digit <= 4'd9 && !entry_full) begin
          buf_d = (buf_q << 4) | (4*NDIG)'(key_digit);
          cnt_d = cnt_q + 1'b1;
        end
      CONV: begin
        // The shift copy presents the most-significant remaining digit at the top nibble.
        acc_d = acc_q * (DW+4)'(10) + (DW+4)'(sh_q[4*NDIG-1 -: 4]);
        ovfi_d = ovfi_q | (|acc_d[DW+3:DW]);
        sh_d = sh_q << 4;
        step_d = step_q + 1'b1;
        state_d = step_q == CW'(NDIG - 1) ? WRITE : CONV;
      end
      WRITE: begin
        we = 1'b1;
        buf_d = '0;
        cnt_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      buf_q <= '0;
      cnt_q <= '0;
      sh_q <= '0;
      step_q <= '0;
      waddr_q <= '0;
      acc_q <= '0;
      ovfi_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q <= 1'b0;
      dout_a_q <= '0;
      dout_b_q <= '0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      step_q <= step_d;
      waddr_q <= waddr_d;
      acc_q <= acc_d;
      ovfi_q <= ovfi_d;
      done_q <= we;
      ovf_q <= we & ovfi_q;
      // Reads sample the array before this edge's write, so no write-through.
      dout_a_q <= rf_q[rd_addr_a];
      dout_b_q <= rf_q[rd_addr_b];
      if (we) rf_q[waddr_q] <= ovfi_q ? '1 : acc_q[DW-1:0];
    end
  end
  assign dout_a = dout_a_q;
  assign dout_b = dout_b_q;
  assign dis_digits = buf_q;
  assign dig_count = cnt_q;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign ovf = ovf_q;
endmodule
